aggregator_arbiter: RTL and testbench
=====================================

// Module: aggregator_arbiter
// PURPOSE
// Shares one aggregator between NUM_SENDERS sender FIFOs. Round-robin picks a non-empty, enabled sender
// and locks the grant for exactly BURST_LEN dequeues, so every wide aggregator word comes from one source.
// Downstream it presents a single FIFO-style read port (data/empty_n/deq) that wires straight to the
// aggregator's sender_* pins. grant_id tags the word being assembled. It is the aggregator's front-end scheduler.
// PARAMETERS
// NUM_SENDERS  4   number of requesting sender FIFOs (>=2)
// DATA_WIDTH   8   width of one sender word
// BURST_LEN    2   words per grant; set equal to the aggregator FETCH_WIDTH (>=1)
// ID_WIDTH     $clog2(NUM_SENDERS)  width of grant_id (localparam)
// PORTS
// clk             in   1                     single clock, all logic on posedge
// rst             in   1                     synchronous, active-high reset
// sender_data     in   NUM_SENDERS*DATA_WIDTH  sender i data at [i*DATA_WIDTH +: DATA_WIDTH]
// sender_empty_n  in   NUM_SENDERS           1 = sender i holds a valid word
// sender_deq      out  NUM_SENDERS           pop strobe to sender i; combinational, one-hot or zero
// req_mask        in   NUM_SENDERS           1 = sender i may be granted; sampled only at arbitration
// out_data        out  DATA_WIDTH            data of the granted sender
// out_empty_n     out  1                     1 = granted sender has a word
// out_deq         in   1                     pop from downstream aggregator
// grant_valid     out  1                     1 = a burst is in progress (state GRANT)
// grant_id        out  ID_WIDTH              index of the granted sender
// burst_done      out  1                     1-cycle pulse, registered, after the final word of a burst is popped
// BEHAVIOUR
// Reset (rst=1 at posedge): state=IDLE, grant_valid=0, grant_id=0, burst_done=0, word count=0,
//   last-grant pointer=NUM_SENDERS-1 (sender 0 has first priority). While in IDLE, sender_deq=0,
//   out_empty_n=0 and out_data=0.
// States: IDLE, GRANT.
// IDLE: req = sender_empty_n & req_mask. If req!=0, choose the first set bit searching upward from
//   last+1 with wrap-around. Next cycle: GRANT, grant_id=choice, last=choice, count=0. If req=0, stay in IDLE.
// GRANT: out_data=sender_data[grant_id], out_empty_n=sender_empty_n[grant_id],
//   sender_deq[grant_id]=out_deq & out_empty_n. All other sender_deq bits are 0.
//   Each effective pop (out_deq & out_empty_n) does count+1.
//   A pop when count==BURST_LEN-1 returns to IDLE and sets burst_done=1 next cycle.
// Arbitration latency: 1 cycle from req to grant_valid. There is 1 IDLE bubble cycle between bursts.
// Mid-burst empty: the grant is held indefinitely (no timeout). out_empty_n=0 and no pop occurs.
//   Other senders are never serviced mid-burst, because partial bursts would misalign aggregator lanes.
// out_deq while out_empty_n=0: ignored. No sender_deq, count unchanged.
// req_mask / sender_empty_n changes during GRANT: no effect on the current burst.
//   Masking the granted sender mid-burst does not revoke it.
// Reset mid-burst: abandons the burst immediately. The next cycle is IDLE, the pointer resets,
//   and no sender_deq is issued in the reset cycle or the cycle after it.
// count width: $clog2(BURST_LEN+1). The count never exceeds BURST_LEN-1.
// TESTING
// 1. Only sender 2 non-empty with 4 words, out_deq=1, BURST_LEN=2 -> grant_id=2 one cycle after req;
//    words popped in order; burst_done pulses twice; 1 bubble cycle between bursts.
// 2. All 4 senders non-empty, mask=4'hF -> grant order 0,1,2,3,0; exactly 2 pops per grant.
// 3. Sender 0 granted, empties after 1 word -> grant_valid held, out_empty_n=0, no other sender_deq;
//    refill -> second word popped, then burst_done and next grant goes to 1.
// 4. All senders non-empty, req_mask=4'b1101 -> grant order 0,2,3,0; sender_deq[1] never asserted.
// 5. rst=1 after 1 of 2 pops in a burst to sender 3 -> next cycle grant_valid=0, sender_deq=0;
//    with all requesting, first grant after reset is sender 0.
// 6. out_deq=1 while the granted sender is empty for 5 cycles -> no sender_deq, count stays 0,
//    no burst_done. Bench checks: data ordering per source, no word loss or duplication.

Source files
------------

// File: rtl/aggregator_arbiter.sv
// aggregator_arbiter: round-robin front-end scheduler for a shared aggregator.
// Each grant is locked for BURST_LEN pops so a wide word comes from one sender.
module aggregator_arbiter #(
    parameter int NUM_SENDERS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_LEN   = 2,
    localparam int ID_WIDTH   = $clog2(NUM_SENDERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SENDERS*DATA_WIDTH-1:0] sender_data,
    input  logic [NUM_SENDERS-1:0]            sender_empty_n,
    output logic [NUM_SENDERS-1:0]            sender_deq,
    input  logic [NUM_SENDERS-1:0]            req_mask,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_empty_n,
    input  logic                              out_deq,
    output logic                              grant_valid,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic                              burst_done
);

    localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]             state;
    logic [ID_WIDTH-1:0]    last;
    logic [ID_WIDTH-1:0]    pick;
    logic [ID_WIDTH-1:0]    idx;
    logic [CNT_WIDTH-1:0]   count;
    logic [NUM_SENDERS-1:0] req;
    logic                   found;
    logic                   pop;

    assign req         = sender_empty_n & req_mask;
    assign grant_valid = (state == GRANT);

    // Search upward from the sender after the last grant, wrapping.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_SENDERS; k++) begin
            idx = ID_WIDTH'((int'(last) + k) % NUM_SENDERS);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        out_data    = '0;
        out_empty_n = 1'b0;
        sender_deq  = '0;
        if (state == GRANT) begin
            for (int i = 0; i < NUM_SENDERS; i++) begin
                if (ID_WIDTH'(i) == grant_id) begin
                    out_data    = sender_data[i*DATA_WIDTH +: DATA_WIDTH];
                    out_empty_n = sender_empty_n[i];
                end
            end
        end
        // A reset cycle must never pop, even mid-burst.
        pop = grant_valid & out_deq & out_empty_n & ~rst;
        for (int i = 0; i < NUM_SENDERS; i++) begin
            sender_deq[i] = pop && (ID_WIDTH'(i) == grant_id);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last       <= ID_WIDTH'(NUM_SENDERS - 1);
            count      <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        grant_id <= pick;
                        last     <= pick;
                        count    <= '0;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        if (count == CNT_WIDTH'(BURST_LEN - 1)) begin
                            state      <= IDLE;
                            count      <= '0;
                            burst_done <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aggregator_arbiter.sv
// tb_aggregator_arbiter: sender FIFO environment, per-source data scoreboard
// and expected grant order queue for aggregator_arbiter.
module tb_aggregator_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int BL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*DW-1:0]  sender_data;
    logic [NS-1:0]     sender_empty_n;
    logic [NS-1:0]     sender_deq;
    logic [NS-1:0]     req_mask;
    logic [DW-1:0]     out_data;
    logic              out_empty_n;
    logic              out_deq;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              burst_done;

    aggregator_arbiter #(
        .NUM_SENDERS(NS),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sender_data   (sender_data),
        .sender_empty_n(sender_empty_n),
        .sender_deq    (sender_deq),
        .req_mask      (req_mask),
        .out_data      (out_data),
        .out_empty_n   (out_empty_n),
        .out_deq       (out_deq),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .burst_done    (burst_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo [NS][$];
    logic [DW-1:0] exp_q[NS][$];
    logic [1:0]    gq[$];
    logic [NS-1:0] hide;
    logic          rnd_deq;
    int            seq;
    int            n_chk;
    int            n_pass;

    logic          b_busy;
    logic          b_bd;
    logic [1:0]    b_g;
    int            b_cnt;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [NS-1:0] vis();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++)
            v[i] = (fifo[i].size() != 0) && !hide[i];
        return v;
    endfunction

    function automatic int left_total();
        int t = 0;
        for (int i = 0; i < NS; i++) t += exp_q[i].size();
        return t;
    endfunction

    task automatic load(int s, int n);
        for (int j = 0; j < n; j++) begin
            logic [DW-1:0] w;
            w = DW'(s * 64 + (seq % 64));
            seq++;
            fifo[s].push_back(w);
            exp_q[s].push_back(w);
        end
    endtask

    task automatic cyc();
        logic [NS-1:0] v, req_b, deq_cap, exp_deq;
        logic          pop, nb, nbd;
        logic [1:0]    ng;
        int            ncnt;
        @(negedge clk);
        v = vis();
        for (int i = 0; i < NS; i++)
            sender_data[i*DW +: DW] = v[i] ? fifo[i][0] : '0;
        sender_empty_n = v;
        if (rnd_deq) out_deq = 1'($urandom_range(0, 1));
        #1;
        req_b = v & req_mask;
        chk("grant_valid", 32'(grant_valid), 32'(b_busy));
        chk("burst_done", 32'(burst_done), 32'(b_bd));
        if (b_busy) chk("grant_id", 32'(grant_id), 32'(b_g));
        chk("out_empty_n", 32'(out_empty_n), 32'(b_busy && v[b_g]));
        pop = b_busy && out_deq && v[b_g] && !rst;
        exp_deq = pop ? (NS'(1) << b_g) : '0;
        chk("sender_deq", 32'(sender_deq), 32'(exp_deq));
        if (pop) begin
            chk("word_avail", 32'(exp_q[b_g].size() != 0), 32'd1);
            if (exp_q[b_g].size() != 0)
                chk("out_data", 32'(out_data), 32'(exp_q[b_g].pop_front()));
        end else if (!b_busy) begin
            chk("idle_data", 32'(out_data), 32'd0);
        end
        deq_cap = sender_deq;
        nb   = b_busy;
        nbd  = 1'b0;
        ng   = b_g;
        ncnt = b_cnt;
        if (rst) begin
            nb   = 1'b0;
            ncnt = 0;
        end else if (b_busy) begin
            if (pop) begin
                if (b_cnt == BL - 1) begin
                    nb   = 1'b0;
                    nbd  = 1'b1;
                    ncnt = 0;
                end else begin
                    ncnt = b_cnt + 1;
                end
            end
        end else if (req_b != '0) begin
            chk("grant_expected", 32'(gq.size() != 0), 32'd1);
            if (gq.size() != 0) begin
                nb   = 1'b1;
                ng   = gq.pop_front();
                ncnt = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (deq_cap[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        b_busy = nb;
        b_bd   = nbd;
        b_g    = ng;
        b_cnt  = ncnt;
    endtask

    task automatic run_n(int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic run(int max);
        int k = 0;
        while (!(gq.size() == 0 && !b_busy && !b_bd) && k < max) begin
            cyc();
            k++;
        end
        chk("done", 32'(gq.size() == 0 && !b_busy && !b_bd), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NS; i++) begin
            fifo[i].delete();
            exp_q[i].delete();
        end
        gq.delete();
        hide     = '0;
        rnd_deq  = 1'b0;
        out_deq  = 1'b0;
        req_mask = 4'hF;
        rst      = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        out_deq        = 1'b0;
        req_mask       = 4'hF;
        hide           = '0;
        rnd_deq        = 1'b0;
        sender_data    = '0;
        sender_empty_n = '0;
        seq            = 0;
        n_chk          = 0;
        n_pass         = 0;
        b_busy         = 1'b0;
        b_bd           = 1'b0;
        b_g            = '0;
        b_cnt          = 0;
        repeat (2) @(posedge clk);
        #1;

        // single requester, two back-to-back bursts with a bubble
        do_reset();
        out_deq = 1'b1;
        load(2, 4);
        gq = {2'd2, 2'd2};
        run(50);
        chk("t1_left", 32'(left_total()), 32'd0);

        // full round robin, random downstream pops
        do_reset();
        rnd_deq = 1'b1;
        load(0, 4);
        load(1, 2);
        load(2, 2);
        load(3, 2);
        gq = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        run(200);
        chk("t2_left", 32'(left_total()), 32'd0);

        // granted sender runs dry mid-burst, then refills
        do_reset();
        out_deq = 1'b1;
        load(0, 1);
        load(1, 2);
        gq = {2'd0, 2'd1};
        run_n(6);
        chk("t3_hold_gv", 32'(grant_valid), 32'd1);
        chk("t3_hold_oen", 32'(out_empty_n), 32'd0);
        load(0, 1);
        run(50);
        chk("t3_left", 32'(left_total()), 32'd0);

        // masked sender is skipped
        do_reset();
        rnd_deq  = 1'b1;
        req_mask = 4'b1101;
        load(0, 4);
        load(1, 2);
        load(2, 2);
        load(3, 2);
        gq = {2'd0, 2'd2, 2'd3, 2'd0};
        run(200);
        chk("t4_masked_left", 32'(exp_q[1].size()), 32'd2);
        chk("t4_left", 32'(left_total()), 32'd2);

        // reset in the middle of a burst
        do_reset();
        out_deq = 1'b1;
        load(3, 2);
        gq = {2'd3};
        run_n(2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_gv_after_rst", 32'(grant_valid), 32'd0);
        load(0, 2);
        load(1, 2);
        load(2, 2);
        load(3, 1);
        gq = {2'd0, 2'd1, 2'd2, 2'd3};
        run(100);
        chk("t5_left", 32'(left_total()), 32'd0);

        // pops ignored while the granted sender looks empty
        do_reset();
        load(1, 2);
        gq = {2'd1};
        run_n(2);
        hide    = 4'b0010;
        out_deq = 1'b1;
        run_n(5);
        chk("t6_stall_gv", 32'(grant_valid), 32'd1);
        hide = '0;
        run(50);
        chk("t6_left", 32'(left_total()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
